// File: rtl/mem_access.sv
// mem_access: RV32I load/store stage between execute and write-back.
// Takes one request per instruction, runs it as a single outstanding
// valid/ready bus transaction, and returns extended load data to the
// register file.
//
// Ports:
//   clk, rst          core clock, async active-high reset
//   req_i .. rd_i     request from execute (store/load, addresses, data,
//                     funct3, destination register)
//   bus_*             valid/ready data bus (addr, wr, wdata, wstrb, rdata)
//   busy_o            combinational pipeline hold
//   done_o            one-cycle completion pulse
//   reg_wr_*, reg_data_o  load write-back
//   err_o             one-cycle pulse on misalignment, bad funct3 or timeout
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_en_i,
    input  logic [31:0] rd_addr_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_wr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        reg_wr_en_o,
    output logic [4:0]  reg_wr_addr_o,
    output logic [31:0] reg_data_o,
    output logic        err_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic              bus_wr_q, bus_wr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              bus_valid_q, bus_valid_d;
    logic              done_q, done_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic [4:0]        reg_wr_addr_q, reg_wr_addr_d;
    logic [XLEN-1:0]   reg_data_q, reg_data_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   req_addr;
    logic              funct3_ok;
    logic              align_ok;
    logic              req_ok;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_value;

    // Request address selection and legality checks.
    always_comb begin
        req_addr = wr_en_i ? wr_addr_i : rd_addr_i;

        funct3_ok = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ~wr_en_i;
            default:                funct3_ok = 1'b0;
        endcase

        align_ok = 1'b1;
        case (funct3_i[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        req_ok = funct3_ok & align_ok;
    end

    // Store lane replication and strobes; loads drive no strobes.
    always_comb begin
        st_wdata = wr_data_i;
        st_wstrb = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{wr_data_i[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wr_data_i[15:0]}};
                st_wstrb = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_wdata = wr_data_i;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!wr_en_i) begin
            st_wdata = '0;
            st_wstrb = 4'b0000;
        end
    end

    // Load lane extraction and sign/zero extension from the latched address.
    always_comb begin
        ld_byte = 8'h00;
        case (bus_addr_q[1:0])
            2'b00:   ld_byte = bus_rdata_i[7:0];
            2'b01:   ld_byte = bus_rdata_i[15:8];
            2'b10:   ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = bus_addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

        ld_value = bus_rdata_i;
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'h000000, ld_byte};
            3'b101:  ld_value = {16'h0000, ld_half};
            default: ld_value = bus_rdata_i;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_d      = bus_wr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        funct3_d      = funct3_q;
        rd_d          = rd_q;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_data_d    = reg_data_q;
        bus_valid_d   = 1'b0;
        done_d        = 1'b0;
        reg_wr_en_d   = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (req_ok) begin
                        state_d     = S_BUS;
                        bus_valid_d = 1'b1;
                        cnt_d       = '0;
                        bus_addr_d  = req_addr;
                        bus_wr_d    = wr_en_i;
                        bus_wdata_d = st_wdata;
                        bus_wstrb_d = st_wstrb;
                        funct3_d    = funct3_i;
                        rd_d        = rd_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (bus_ready_i) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!bus_wr_q) begin
                        reg_wr_en_d   = (rd_q != 5'd0);
                        reg_wr_addr_d = rd_q;
                        reg_data_d    = ld_value;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Expiry: abandon the access without write-back.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    bus_valid_d = 1'b1;
                    cnt_d       = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bus_addr_q    <= '0;
            bus_wr_q      <= 1'b0;
            bus_wdata_q   <= '0;
            bus_wstrb_q   <= 4'b0000;
            funct3_q      <= 3'b000;
            rd_q          <= 5'd0;
            bus_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= 5'd0;
            reg_data_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_q      <= bus_wr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
            funct3_q      <= funct3_d;
            rd_q          <= rd_d;
            bus_valid_q   <= bus_valid_d;
            done_q        <= done_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_data_q    <= reg_data_d;
            err_q         <= err_d;
        end
    end

    // Hold execute in the request cycle itself, and throughout the bus phase.
    assign busy_o = (state_q == S_BUS) | ((state_q == S_IDLE) & req_i & req_ok);

    assign bus_valid_o   = bus_valid_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wr_o      = bus_wr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_wstrb_o   = bus_wstrb_q;
    assign done_o        = done_q;
    assign reg_wr_en_o   = reg_wr_en_q;
    assign reg_wr_addr_o = reg_wr_addr_q;
    assign reg_data_o    = reg_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (timeout shortened to 4).
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        wr_en_i;
    logic [31:0] rd_addr_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic [31:0] bus_addr_o;
    logic        bus_wr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        reg_wr_en_o;
    logic [4:0]  reg_wr_addr_o;
    logic [31:0] reg_data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .wr_en_i       (wr_en_i),
        .rd_addr_i     (rd_addr_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .funct3_i      (funct3_i),
        .rd_i          (rd_i),
        .bus_valid_o   (bus_valid_o),
        .bus_ready_i   (bus_ready_i),
        .bus_addr_o    (bus_addr_o),
        .bus_wr_o      (bus_wr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_rdata_i   (bus_rdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_addr_o (reg_wr_addr_o),
        .reg_data_o    (reg_data_o),
        .err_o         (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        checks++; if (bus_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_valid_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
        checks++; if (reg_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", reg_wr_en_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (reg_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", reg_data_o); end
        checks++; if (bus_wstrb_o !== 4'h0) begin errors++; $display("FAIL reset_wstrb got %b exp 0", bus_wstrb_o); end
        rst = 1'b0;
        cyc();
    endtask

    // Store with a zero-wait bus: ready is already high in the first BUS cycle.
    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb);
        req_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = addr; rd_addr_i = 32'hFFFF_FFF1;
        wr_data_i = data; funct3_i = f3; rd_i = 5'd3; bus_ready_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s req_busy got %b exp 1", nm, busy_o); end
        cyc();
        req_i = 1'b0;
        checks++; if (bus_valid_o !== 1'b1 || bus_wr_o !== 1'b1) begin errors++; $display("FAIL %s valid_wr got %b%b exp 11", nm, bus_valid_o, bus_wr_o); end
        checks++; if (bus_addr_o !== addr) begin errors++; $display("FAIL %s addr got %h exp %h", nm, bus_addr_o, addr); end
        checks++; if (bus_wdata_o !== exp_wdata) begin errors++; $display("FAIL %s wdata got %h exp %h", nm, bus_wdata_o, exp_wdata); end
        checks++; if (bus_wstrb_o !== exp_wstrb) begin errors++; $display("FAIL %s wstrb got %b exp %b", nm, bus_wstrb_o, exp_wstrb); end
        cyc();
        bus_ready_i = 1'b0;
        checks++; if (done_o !== 1'b1 || reg_wr_en_o !== 1'b0 || bus_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s done/we/valid got %b%b%b exp 100", nm, done_o, reg_wr_en_o, bus_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s done_busy got %b exp 0", nm, busy_o); end
        cyc();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s done_clear got %b exp 0", nm, done_o); end
    endtask

    // Load with a given number of wait cycles before ready.
    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_data, input logic exp_we);
        int busy_n;
        busy_n = 0;
        req_i = 1'b1; wr_en_i = 1'b0; rd_addr_i = addr; wr_addr_i = 32'hFFFF_FFF3;
        wr_data_i = 32'h5555_5555; funct3_i = f3; rd_i = rd; bus_ready_i = 1'b0; bus_rdata_i = rdata;
        #1;
        if (busy_o === 1'b1) busy_n++;
        cyc();
        req_i = 1'b0;
        checks++; if (bus_valid_o !== 1'b1 || bus_wr_o !== 1'b0 || bus_wstrb_o !== 4'h0) begin
            errors++; $display("FAIL %s bus_rd got valid %b wr %b wstrb %b exp 1 0 0000", nm, bus_valid_o, bus_wr_o, bus_wstrb_o); end
        checks++; if (bus_addr_o !== addr) begin errors++; $display("FAIL %s addr got %h exp %h", nm, bus_addr_o, addr); end
        for (int k = 0; k <= waits; k++) begin
            bus_ready_i = (k == waits);
            if (busy_o === 1'b1) busy_n++;
            cyc();
        end
        bus_ready_i = 1'b0;
        bus_rdata_i = 32'h0;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", nm, done_o); end
        checks++; if (reg_wr_en_o !== exp_we) begin errors++; $display("FAIL %s we got %b exp %b", nm, reg_wr_en_o, exp_we); end
        checks++; if (reg_data_o !== exp_data) begin errors++; $display("FAIL %s data got %h exp %h", nm, reg_data_o, exp_data); end
        checks++; if (reg_wr_addr_o !== rd) begin errors++; $display("FAIL %s rd got %0d exp %0d", nm, reg_wr_addr_o, rd); end
        checks++; if (busy_n !== waits + 2) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", nm, busy_n, waits + 2); end
        cyc();
        checks++; if (done_o !== 1'b0 || reg_wr_en_o !== 1'b0) begin errors++; $display("FAIL %s pulse_clear got %b%b exp 00", nm, done_o, reg_wr_en_o); end
    endtask

    task automatic test_stores();
        do_store("sw", 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000);
        do_store("sh", 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100);
    endtask

    task automatic test_loads();
        do_load("lb",  3'b000, 32'h0000_2002, 5'd5, 32'h80FF_7F01, 3, 32'hFFFF_FFFF, 1'b1);
        do_load("lbu", 3'b100, 32'h0000_2002, 5'd5, 32'h80FF_7F01, 3, 32'h0000_00FF, 1'b1);
        do_load("lh",  3'b001, 32'h0000_2002, 5'd7, 32'h80FF_7F01, 0, 32'hFFFF_80FF, 1'b1);
        do_load("lhu", 3'b101, 32'h0000_2000, 5'd7, 32'h80FF_7F01, 1, 32'h0000_7F01, 1'b1);
        do_load("lb1", 3'b000, 32'h0000_2001, 5'd2, 32'h80FF_7F01, 0, 32'h0000_007F, 1'b1);
    endtask

    task automatic test_rd_zero();
        do_load("lw_rd0", 3'b010, 32'h0000_4000, 5'd0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0);
    endtask

    // Rejected requests: misaligned half, illegal load funct3, load-only funct3 on a store.
    task automatic test_reject();
        logic [2:0]  f3   [3] = '{3'b001, 3'b011, 3'b100};
        logic [31:0] adr  [3] = '{32'h0000_2001, 32'h0000_2000, 32'h0000_3000};
        logic        wr   [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            req_i = 1'b1; wr_en_i = wr[i]; rd_addr_i = adr[i]; wr_addr_i = adr[i];
            funct3_i = f3[i]; rd_i = 5'd4; bus_ready_i = 1'b0;
            #1;
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reject%0d busy got %b exp 0", i, busy_o); end
            cyc();
            req_i = 1'b0;
            checks++; if (err_o !== 1'b1 || bus_valid_o !== 1'b0) begin errors++; $display("FAIL reject%0d err/valid got %b%b exp 10", i, err_o, bus_valid_o); end
            cyc();
            checks++; if (err_o !== 1'b0 || bus_valid_o !== 1'b0) begin errors++; $display("FAIL reject%0d clear got %b%b exp 00", i, err_o, bus_valid_o); end
        end
    endtask

    task automatic test_timeout();
        req_i = 1'b1; wr_en_i = 1'b0; rd_addr_i = 32'h0000_3000; funct3_i = 3'b010; rd_i = 5'd6; bus_ready_i = 1'b0;
        cyc();
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_valid_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL timeout_bus%0d valid/err got %b%b exp 10", i, bus_valid_o, err_o); end
            cyc();
        end
        checks++; if (bus_valid_o !== 1'b0 || err_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL timeout_expire valid/err/done got %b%b%b exp 010", bus_valid_o, err_o, done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy_o); end
        cyc();
        checks++; if (err_o !== 1'b0 || done_o !== 1'b0 || reg_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL timeout_after err/done/we got %b%b%b exp 000", err_o, done_o, reg_wr_en_o); end
    endtask

    task automatic test_reset_mid();
        req_i = 1'b1; wr_en_i = 1'b0; rd_addr_i = 32'h0000_5000; funct3_i = 3'b010; rd_i = 5'd8; bus_ready_i = 1'b0;
        cyc();
        req_i = 1'b0;
        checks++; if (bus_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre valid got %b exp 1", bus_valid_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_async valid/busy got %b%b exp 00", bus_valid_o, busy_o); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (err_o !== 1'b0 || done_o !== 1'b0 || reg_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_post err/done/we got %b%b%b exp 000", err_o, done_o, reg_wr_en_o); end
        do_load("lw_after_rst", 3'b010, 32'h0000_6004, 5'd9, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b1);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; wr_en_i = 1'b0; rd_addr_i = '0; wr_addr_i = '0;
        wr_data_i = '0; funct3_i = '0; rd_i = '0; bus_ready_i = 1'b0; bus_rdata_i = '0;
        test_reset();
        test_stores();
        test_loads();
        test_rd_zero();
        test_reject();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store stage sitting directly downstream of the execution stage in the RISC-V core. Accepts one memory request per instruction from execution and runs it on a single-outstanding valid/ready data bus. Formats store byte lanes and sign/zero-extends load data. Stalls the pipeline while the access is in flight and returns load results to the register write-back path.

## Interface
- TIMEOUT_CYCLES, 255: max BUS-state cycles without bus_ready_i before abort (1..65535).

- clk  in  1  single core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_i  in  1  memory request from execution (its mem_req_o).
- wr_en_i  in  1  1 = store, 0 = load.
- rd_addr_i  in  32  load byte address.
- wr_addr_i  in  32  store byte address.
- wr_data_i  in  32  store data (rs2 value, unaligned in low bits).
- funct3_i  in  3  access size/sign (RV32I load/store funct3).
- rd_i  in  5  load destination register.
- bus_valid_o  out  1  bus request valid.
- bus_ready_i  in  1  bus accepts / completes request this cycle.
- bus_addr_o  out  32  byte address.
- bus_wr_o  out  1  1 = write.
- bus_wdata_o  out  32  lane-replicated write data.
- bus_wstrb_o  out  4  byte-lane write strobes (0 for reads).
- bus_rdata_i  in  32  read data, valid when bus_valid_o & bus_ready_i & !bus_wr_o.
- busy_o  out  1  pipeline hold request.
- done_o  out  1  one-cycle completion pulse.
- reg_wr_en_o  out  1  load write-back enable (one cycle, with done_o).
- reg_wr_addr_o  out  5  load destination.
- reg_data_o  out  32  extended load data.
- err_o  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.

## Operation
- States: IDLE, BUS, DONE. Reset → IDLE; all outputs 0, timeout counter 0.
- IDLE, req_i=1: address = wr_addr_i if wr_en_i else rd_addr_i. Check:
  - legal funct3: loads 000,001,010,100,101; stores 000,001,010.
  - alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - Fail → err_o pulses the next cycle, no bus activity, stay IDLE.
  - Pass → latch address, funct3, rd, wr flag, data → BUS.
- Store formatting: SB wdata={4{b}}, wstrb=0001<<addr[1:0]; SH wdata={2{h}}, wstrb=0011<<addr[1:0]; SW wstrb=1111.
- BUS: bus_valid_o=1. bus_addr/wr/wdata/wstrb held stable until bus_ready_i. On handshake, capture bus_rdata_i → DONE. Counter increments each BUS cycle without ready. On reaching TIMEOUT_CYCLES → drop valid, err_o pulse, no write-back, → IDLE.
- Load extraction (registered at handshake): byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]. LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
- DONE: done_o=1 for one cycle. Loads: reg_wr_en_o=1 unless rd=0, reg_wr_addr_o=rd, reg_data_o=value. Stores: reg_wr_en_o=0. → IDLE.
- reg_data_o/reg_wr_addr_o hold their last value; only reg_wr_en_o qualifies them.
- busy_o = (state==BUS) | (state==IDLE & req_i & checks pass). Combinational, so execution holds in the request cycle. 0 in DONE.
- req_i outside IDLE is ignored; upstream holds because busy_o=1.

## Timing
- Request accepted at edge N; bus_valid_o high from cycle N+1.
- Handshake in cycle M (≥N+1): done_o/reg_wr_en_o in cycle M+1.
- Zero-wait bus gives 3-cycle occupancy (IDLE, BUS, DONE). A new req_i is accepted in the cycle after DONE.
- Error pulse is one cycle after the rejected request, or in the cycle after the timeout expiry.
- rst mid-transaction: bus_valid_o, done_o, reg_wr_en_o and err_o drop immediately (async). No write-back or error is emitted.

## Test plan
- SW addr 0x1000 data 0xDEADBEEF, bus_ready_i=1 same cycle as valid → wstrb 1111, wdata 0xDEADBEEF, done_o at N+2, reg_wr_en_o=0.
- SB addr 0x1003 data 0x000000A5 → wdata 0xA5A5A5A5, wstrb 1000.
- LB addr 0x2002, rdata 0x80FF7F01, rd=5, ready after 3 wait cycles → reg_data_o 0xFFFFFFFF, reg_wr_en_o=1 with rd 5; busy_o high 5 cycles. LBU same → 0x000000FF.
- LH addr 0x2001 → err_o pulse, bus_valid_o never asserts. Load funct3 011 → err_o.
- TIMEOUT_CYCLES=4, ready held 0 → valid drops after 4 BUS cycles, err_o pulse, no done_o. LW with rd=0 → done_o=1, reg_wr_en_o=0.
- Assert rst during BUS with ready low → valid drops in the same cycle. After release, next request proceeds normally.
